// File: rtl/tron_input_ctrl_pkg.sv
// Shared Tron input types: directions, PS/2 prefix bytes, per-player keymap and start directions.
package tron_input_ctrl_pkg;

  typedef enum logic [1:0] {
    UP    = 2'd0,
    RIGHT = 2'd1,
    DOWN  = 2'd2,
    LEFT  = 2'd3
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_EXT     = 2'd1,
    ST_BRK     = 2'd2,
    ST_EXT_BRK = 2'd3
  } prefix_t;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
  } key_t;

  localparam logic [7:0] PS2_EXT   = 8'hE0;
  localparam logic [7:0] PS2_BRK   = 8'hF0;
  localparam logic [7:0] PS2_SPACE = 8'h29;

  localparam int unsigned MAX_PLAYERS = 4;
  localparam int unsigned NUM_KEYS    = 4;

  // Column order of KEYMAP rows
  localparam dir_t KEY_DIR [NUM_KEYS] = '{UP, DOWN, LEFT, RIGHT};

  localparam key_t KEYMAP [MAX_PLAYERS][NUM_KEYS] = '{
    '{'{8'h1D, 1'b0}, '{8'h1B, 1'b0}, '{8'h1C, 1'b0}, '{8'h23, 1'b0}},
    '{'{8'h75, 1'b1}, '{8'h72, 1'b1}, '{8'h6B, 1'b1}, '{8'h74, 1'b1}},
    '{'{8'h43, 1'b0}, '{8'h42, 1'b0}, '{8'h3B, 1'b0}, '{8'h4B, 1'b0}},
    '{'{8'h75, 1'b0}, '{8'h72, 1'b0}, '{8'h6B, 1'b0}, '{8'h74, 1'b0}}
  };

  localparam dir_t DEFAULT_DIR [MAX_PLAYERS] = '{RIGHT, LEFT, DOWN, UP};

  // Encoding places opposites two apart, so flipping the MSB reverses a direction
  function automatic dir_t opposite(input dir_t d);
    return dir_t'({~d[1], d[0]});
  endfunction

endpackage

// File: rtl/tron_input_ctrl_dir_queue.sv
// Per-player circular FIFO of pending turns; rejects duplicates and reversals of ref_dir.
module dir_queue
  import tron_input_ctrl_pkg::*;
#(
  parameter int unsigned DEPTH = 2
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic                       push,
  input  dir_t                       push_dir,
  input  dir_t                       ref_dir,
  input  logic                       pop,
  input  logic                       flush,
  output dir_t                       head,
  output dir_t                       tail,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  dir_t             mem [DEPTH];
  dir_t             tail_q;
  logic [PTR_W-1:0] rd_ptr;
  logic [PTR_W-1:0] wr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             accept_c;
  logic             do_pop_c;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : PTR_W'(p + PTR_W'(1));
  endfunction

  // Full is judged on the pre-pop count, so a push into a full queue drops even on a tick
  always_comb begin
    do_pop_c = pop && (cnt != '0);
    accept_c = push
            && (push_dir != ref_dir)
            && (push_dir != opposite(ref_dir))
            && (cnt < CNT_W'(DEPTH));
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
      tail_q <= UP;
      for (int unsigned i = 0; i < DEPTH; i++) mem[i] <= UP;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (accept_c) begin
        mem[wr_ptr] <= push_dir;
        wr_ptr      <= next_ptr(wr_ptr);
        tail_q      <= push_dir;
      end
      if (do_pop_c) rd_ptr <= next_ptr(rd_ptr);
      case ({accept_c, do_pop_c})
        2'b10:   cnt <= CNT_W'(cnt + CNT_W'(1));
        2'b01:   cnt <= CNT_W'(cnt - CNT_W'(1));
        default: cnt <= cnt;
      endcase
    end
  end

  assign head  = mem[rd_ptr];
  assign tail  = tail_q;
  assign count = cnt;

endmodule

// File: rtl/tron_input_ctrl.sv
// PS/2 byte stream to per-player Tron directions: prefix decode, keymap match, turn queues, restart.
module tron_input_ctrl
  import tron_input_ctrl_pkg::*;
#(
  parameter int unsigned NUM_PLAYERS = 2,
  parameter int unsigned QUEUE_DEPTH = 2
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   code_new,
  input  logic [7:0]             code,
  input  logic                   tick,
  output dir_t [NUM_PLAYERS-1:0] dir,
  output logic                   restart
);

  localparam int unsigned CNT_W = $clog2(QUEUE_DEPTH + 1);

  prefix_t          state;
  logic             code_new_q;
  logic             strobe_c;
  logic             prefix_byte_c;
  logic             key_evt_c;
  logic             ev_ext_c;
  logic             ev_brk_c;
  logic             space_evt_c;
  logic             pop_c;
  logic             push_c     [NUM_PLAYERS];
  dir_t             push_dir_c [NUM_PLAYERS];
  dir_t             ref_dir_c  [NUM_PLAYERS];
  dir_t             q_head     [NUM_PLAYERS];
  dir_t             q_tail     [NUM_PLAYERS];
  logic [CNT_W-1:0] q_count    [NUM_PLAYERS];

  // Byte decode: a key event is any non-prefix byte, qualified by the accumulated prefixes
  always_comb begin
    strobe_c      = code_new && !code_new_q;
    prefix_byte_c = (code == PS2_EXT) || (code == PS2_BRK);
    key_evt_c     = strobe_c && !prefix_byte_c;
    ev_ext_c      = (state == ST_EXT) || (state == ST_EXT_BRK);
    ev_brk_c      = (state == ST_BRK) || (state == ST_EXT_BRK);
    space_evt_c   = key_evt_c && ev_brk_c && !ev_ext_c && (code == PS2_SPACE);
    pop_c         = tick && !space_evt_c;
  end

  // Keymap match for make events; reference is the newest queued turn, else the live direction
  always_comb begin
    for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
      push_c[p]     = 1'b0;
      push_dir_c[p] = UP;
      ref_dir_c[p]  = (q_count[p] == '0) ? dir[p] : q_tail[p];
      if (key_evt_c && !ev_brk_c) begin
        for (int unsigned k = 0; k < NUM_KEYS; k++) begin
          if ((code == KEYMAP[p][k].code) && (ev_ext_c == KEYMAP[p][k].ext)) begin
            push_c[p]     = 1'b1;
            push_dir_c[p] = KEY_DIR[k];
          end
        end
      end
    end
  end

  // Prefix FSM, byte edge register and restart pulse
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      code_new_q <= 1'b0;
      restart    <= 1'b0;
    end else begin
      code_new_q <= code_new;
      restart    <= space_evt_c;
      if (strobe_c) begin
        if (code == PS2_EXT) begin
          state <= ST_EXT;
        end else if (code == PS2_BRK) begin
          state <= ev_ext_c ? ST_EXT_BRK : ST_BRK;
        end else begin
          state <= ST_IDLE;
        end
      end
    end
  end

  // Live directions: restart restores defaults and overrides a coincident tick
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int unsigned p = 0; p < NUM_PLAYERS; p++) dir[p] <= DEFAULT_DIR[p];
    end else if (space_evt_c) begin
      for (int unsigned p = 0; p < NUM_PLAYERS; p++) dir[p] <= DEFAULT_DIR[p];
    end else if (tick) begin
      for (int unsigned p = 0; p < NUM_PLAYERS; p++) begin
        if (q_count[p] != '0) dir[p] <= q_head[p];
      end
    end
  end

  for (genvar g = 0; g < NUM_PLAYERS; g++) begin : g_queue
    dir_queue #(
      .DEPTH (QUEUE_DEPTH)
    ) u_dir_queue (
      .clock    (clock),
      .reset    (reset),
      .push     (push_c[g]),
      .push_dir (push_dir_c[g]),
      .ref_dir  (ref_dir_c[g]),
      .pop      (pop_c),
      .flush    (space_evt_c),
      .head     (q_head[g]),
      .tail     (q_tail[g]),
      .count    (q_count[g])
    );
  end

endmodule

// File: tb/tb_tron_input_ctrl.sv
// Directed bench for tron_input_ctrl (2 players, depth 2) with an expectation queue.
module tb_tron_input_ctrl;
  import tron_input_ctrl_pkg::*;

  logic           clock = 1'b0;
  logic           reset;
  logic           code_new;
  logic [7:0]     code;
  logic           tick;
  dir_t [1:0]     dir;
  logic           restart;

  typedef struct {
    string      tag;
    logic [4:0] exp;
  } sb_t;

  sb_t sb[$];
  int  n_vec = 0;
  int  n_err = 0;

  always #5 clock = ~clock;

  tron_input_ctrl #(
    .NUM_PLAYERS (2),
    .QUEUE_DEPTH (2)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .code_new (code_new),
    .code     (code),
    .tick     (tick),
    .dir      (dir),
    .restart  (restart)
  );

  // Expected word layout: {restart, dir[1], dir[0]}
  task automatic expect_out(input string tag, input logic r, input dir_t d1, input dir_t d0);
    sb_t e;
    e.tag = tag;
    e.exp = {r, d1, d0};
    sb.push_back(e);
  endtask

  task automatic check_out();
    sb_t        e;
    logic [4:0] obs;
    if (sb.size() == 0) begin
      n_vec++;
      n_err++;
      $error("FAIL scoreboard_underflow: observed empty queue expected entry");
    end else begin
      e   = sb.pop_front();
      obs = {restart, dir};
      n_vec++;
      assert (obs === e.exp) else begin
        n_err++;
        $error("FAIL %s: observed %b expected %b", e.tag, obs, e.exp);
      end
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  // One byte with an optional coincident tick; checks the cycle right after the strobe
  task automatic send(input logic [7:0] b, input logic tk, input string tag,
                      input logic r, input dir_t d1, input dir_t d0);
    code     = b;
    code_new = 1'b1;
    tick     = tk;
    expect_out(tag, r, d1, d0);
    cyc();
    check_out();
    code_new = 1'b0;
    tick     = 1'b0;
    cyc();
  endtask

  task automatic do_tick(input string tag, input dir_t d1, input dir_t d0);
    tick = 1'b1;
    expect_out(tag, 1'b0, d1, d0);
    cyc();
    tick = 1'b0;
    check_out();
  endtask

  initial begin
    reset    = 1'b1;
    code_new = 1'b0;
    code     = 8'h00;
    tick     = 1'b0;
    cyc();
    cyc();
    expect_out("reset_state", 1'b0, LEFT, RIGHT);
    check_out();
    reset = 1'b0;
    cyc();

    // Reset asserted mid-cycle while the FSM sits in EXT
    send(8'hE0, 1'b0, "t1_e0", 1'b0, LEFT, RIGHT);
    reset = 1'b1;
    #2;
    reset = 1'b0;
    cyc();
    expect_out("t1_after_reset", 1'b0, LEFT, RIGHT);
    check_out();
    send(8'h74, 1'b0, "t1_74_plain", 1'b0, LEFT, RIGHT);
    send(8'h72, 1'b0, "t1_72_plain", 1'b0, LEFT, RIGHT);
    do_tick("t1_tick_p1_unchanged", LEFT, RIGHT);

    // Reversal and duplicate rejection for P0 at RIGHT
    send(8'h1C, 1'b0, "t3_left_rev", 1'b0, LEFT, RIGHT);
    send(8'h23, 1'b0, "t3_right_dup", 1'b0, LEFT, RIGHT);
    do_tick("t3_tick_keeps_right", LEFT, RIGHT);

    // Two turns inside one step, applied one per tick
    send(8'h1D, 1'b0, "t2_w", 1'b0, LEFT, RIGHT);
    send(8'h1C, 1'b0, "t2_a", 1'b0, LEFT, RIGHT);
    do_tick("t2_tick1_up", LEFT, UP);
    do_tick("t2_tick2_left", LEFT, LEFT);
    do_tick("t2_tick3_hold", LEFT, LEFT);

    // P1 queue overflow: UP, RIGHT accepted, DOWN dropped
    send(8'hE0, 1'b0, "t4_e0a", 1'b0, LEFT, LEFT);
    send(8'h75, 1'b0, "t4_up", 1'b0, LEFT, LEFT);
    send(8'hE0, 1'b0, "t4_e0b", 1'b0, LEFT, LEFT);
    send(8'h74, 1'b0, "t4_right", 1'b0, LEFT, LEFT);
    send(8'hE0, 1'b0, "t4_e0c", 1'b0, LEFT, LEFT);
    send(8'h72, 1'b0, "t4_down_full", 1'b0, LEFT, LEFT);
    do_tick("t4_tick1_up", UP, LEFT);
    do_tick("t4_tick2_right", RIGHT, LEFT);
    do_tick("t4_tick3_no_down", RIGHT, LEFT);

    // Extended break pushes nothing; plain 75 belongs to absent P3
    send(8'hE0, 1'b0, "t5_e0", 1'b0, RIGHT, LEFT);
    send(8'hF0, 1'b0, "t5_f0", 1'b0, RIGHT, LEFT);
    send(8'h75, 1'b0, "t5_release", 1'b0, RIGHT, LEFT);
    do_tick("t5_tick_no_push", RIGHT, LEFT);
    send(8'h75, 1'b0, "t5_plain_75", 1'b0, RIGHT, LEFT);
    do_tick("t5_tick_p3_ignored", RIGHT, LEFT);
    send(8'h1D, 1'b0, "t5_fsm_idle_w", 1'b0, RIGHT, LEFT);
    do_tick("t5_tick_p0_up", RIGHT, UP);

    // Space release with queued turns and a coincident tick
    send(8'h23, 1'b0, "t6_q_p0_right", 1'b0, RIGHT, UP);
    send(8'hE0, 1'b0, "t6_e0", 1'b0, RIGHT, UP);
    send(8'h72, 1'b0, "t6_q_p1_down", 1'b0, RIGHT, UP);
    send(8'hF0, 1'b0, "t6_f0", 1'b0, RIGHT, UP);
    send(8'h29, 1'b1, "t6_restart_pulse", 1'b1, LEFT, RIGHT);
    expect_out("t6_restart_low", 1'b0, LEFT, RIGHT);
    check_out();
    do_tick("t6_tick_queues_flushed", LEFT, RIGHT);
    send(8'h29, 1'b0, "t6_space_make", 1'b0, LEFT, RIGHT);

    // Push coincident with tick on an empty queue: no bypass
    send(8'h1D, 1'b1, "t7_push_tick_empty", 1'b0, LEFT, RIGHT);
    do_tick("t7_next_tick_up", LEFT, UP);

    // Push coincident with pop: reference is the pre-pop tail
    send(8'h1C, 1'b0, "t7_q_left", 1'b0, LEFT, UP);
    send(8'h1B, 1'b1, "t7_push_pop", 1'b0, LEFT, LEFT);
    do_tick("t7_tick_down", LEFT, DOWN);
    do_tick("t7_tick_hold", LEFT, DOWN);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
